// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt request collector and vectoring stage for the microsequencer.
// Latency: i_req sampled into pending at edge N, offered (o_irq=1) at edge N+1.
// Backpressure: a single offer is held stable until i_ack. New requests keep accumulating in pending meanwhile.
//
// Ports:
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   i_req              level-sampled request lines, bit 0 = highest priority
//   i_mask             1 = source may compete, 0 = source is held pending only
//   i_clr, i_clr_num   software clear of one pending bit
//   i_tab_we/addr/data vector table write port (synchronous write)
//   i_ack              sequencer accepted the current offer
//   o_irq              an interrupt is being offered
//   o_num, o_vector    offered interrupt number and its microcode address
//   o_pending          pending register, for trace/debug
//
// Build option: define INTR_NMI_EN to make sources 0 and 1 non-maskable.

module intr_ctrl #(
    parameter int NINTR = 32,
    parameter int VEC_W = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NINTR-1:0] i_req,
    input  logic [NINTR-1:0] i_mask,
    input  logic             i_clr,
    input  logic [4:0]       i_clr_num,
    input  logic             i_tab_we,
    input  logic [4:0]       i_tab_addr,
    input  logic [VEC_W-1:0] i_tab_data,
    input  logic             i_ack,
    output logic             o_irq,
    output logic [4:0]       o_num,
    output logic [VEC_W-1:0] o_vector,
    output logic [NINTR-1:0] o_pending
);

    localparam int AW = (NINTR > 1) ? $clog2(NINTR) : 1;
    localparam logic [NINTR-1:0] ONE = NINTR'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OFFER  = 2'd1,
        SETTLE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NINTR-1:0]  pend_q;
    logic [NINTR-1:0]  pend_d;
    logic [4:0]        num_q, num_d;
    logic [VEC_W-1:0]  vec_q, vec_d;
    logic [VEC_W-1:0]  tab [NINTR];

    logic              ack_fire;
    logic [NINTR-1:0]  clr_oh;
    logic [NINTR-1:0]  ack_oh;
    logic [NINTR-1:0]  tab_we_oh;
    logic [NINTR-1:0]  eff_mask;
    logic [NINTR-1:0]  req_m;
    logic [AW-1:0]     cand_idx;
    logic              cand_vld;

    // The offer is defined purely by the state register so that an
    // asynchronous reset withdraws it immediately.
    assign o_irq     = (state_q == OFFER);
    assign o_num     = num_q;
    assign o_vector  = vec_q;
    assign o_pending = pend_q;

    // Acks arriving while nothing is offered have no effect.
    assign ack_fire = o_irq & i_ack;

    // One-hot decodes by shifting: any index >= NINTR shifts out of the
    // vector and therefore touches nothing.
    assign clr_oh    = i_clr    ? (ONE << i_clr_num)  : '0;
    assign ack_oh    = ack_fire ? (ONE << o_num)      : '0;
    assign tab_we_oh = i_tab_we ? (ONE << i_tab_addr) : '0;

`ifdef INTR_NMI_EN
    // Memory block absent and multiple error cannot be masked off.
    localparam logic [NINTR-1:0] NMI_BITS = NINTR'(3);
    assign eff_mask = i_mask | NMI_BITS;
`else
    assign eff_mask = i_mask;
`endif

    // Set has priority over both clear sources so a request raised in
    // the same cycle as its own ack or software clear is never lost.
    assign pend_d = (pend_q & ~(clr_oh | ack_oh)) | i_req;

    // Candidate comes from the registered pending bits, never directly
    // from i_req; this is what gives the one-edge request-to-offer delay.
    assign req_m    = pend_q & eff_mask;
    assign cand_vld = |req_m;

    always_comb begin
        cand_idx = '0;
        // Scan from the top so the lowest set index is the last writer.
        for (int b = NINTR - 1; b >= 0; b--) begin
            if (req_m[b]) begin
                cand_idx = AW'(b);
            end
        end
    end

    // Pending register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Vector table: synchronous write, combinational read. A write and an
    // IDLE latch of the same entry on one edge latch the old contents,
    // because the read below sees the pre-edge table value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NINTR; b++) begin
                tab[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NINTR; b++) begin
                if (tab_we_oh[b]) begin
                    tab[b] <= i_tab_data;
                end
            end
        end
    end

    // State and offer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            num_q   <= '0;
            vec_q   <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            vec_q   <= vec_d;
        end
    end

    // Next-state logic. Number and vector are captured only in IDLE, so
    // during OFFER they ignore mask changes, new higher-priority requests
    // and table rewrites.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vec_d   = vec_q;
        unique case (state_q)
            IDLE: begin
                if (cand_vld) begin
                    num_d   = 5'(cand_idx);
                    vec_d   = tab[cand_idx];
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (ack_fire) begin
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                // Dead cycle: the acked bit's clear is visible before the
                // next priority evaluation.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed testbench for intr_ctrl: reset, basic grant, priority,
// masking, offer hold, set-over-clear, table collision, NMI and reset
// during an offer.

module tb_intr_ctrl;

    localparam int NINTR = 32;
    localparam int VEC_W = 12;

    logic             clk;
    logic             reset;
    logic [NINTR-1:0] i_req;
    logic [NINTR-1:0] i_mask;
    logic             i_clr;
    logic [4:0]       i_clr_num;
    logic             i_tab_we;
    logic [4:0]       i_tab_addr;
    logic [VEC_W-1:0] i_tab_data;
    logic             i_ack;
    logic             o_irq;
    logic [4:0]       o_num;
    logic [VEC_W-1:0] o_vector;
    logic [NINTR-1:0] o_pending;

    int n_cmp = 0;
    int n_err = 0;

    intr_ctrl #(.NINTR(NINTR), .VEC_W(VEC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_mask     (i_mask),
        .i_clr      (i_clr),
        .i_clr_num  (i_clr_num),
        .i_tab_we   (i_tab_we),
        .i_tab_addr (i_tab_addr),
        .i_tab_data (i_tab_data),
        .i_ack      (i_ack),
        .o_irq      (o_irq),
        .o_num      (o_num),
        .o_vector   (o_vector),
        .o_pending  (o_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Inputs change at the falling edge; outputs are sampled there too.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic tab_write(input logic [4:0] a, input logic [VEC_W-1:0] d);
        i_tab_we = 1'b1; i_tab_addr = a; i_tab_data = d;
        step();
        i_tab_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        i_req = '0; i_mask = '1; i_clr = 1'b0; i_clr_num = '0;
        i_tab_we = 1'b0; i_tab_addr = '0; i_tab_data = '0; i_ack = 1'b0;
        step(); step();
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL reset_irq got=%b exp=0", o_irq); end
        n_cmp++; if (o_num !== 5'd0) begin n_err++; $display("FAIL reset_num got=%0d exp=0", o_num); end
        n_cmp++; if (o_vector !== 12'h000) begin n_err++; $display("FAIL reset_vec got=%h exp=000", o_vector); end
        n_cmp++; if (o_pending !== 32'h0) begin n_err++; $display("FAIL reset_pend got=%h exp=0", o_pending); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        tab_write(5'd5, 12'h44E);
        i_req = 32'h1 << 5;
        step();                       // pending set, still idle
        i_req = '0;
        n_cmp++; if (o_pending !== 32'h20) begin n_err++; $display("FAIL basic_pend got=%h exp=00000020", o_pending); end
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL basic_early_irq got=%b exp=0", o_irq); end
        step();                       // offered
        n_cmp++; if (o_irq !== 1'b1) begin n_err++; $display("FAIL basic_irq got=%b exp=1", o_irq); end
        n_cmp++; if (o_num !== 5'd5) begin n_err++; $display("FAIL basic_num got=%0d exp=5", o_num); end
        n_cmp++; if (o_vector !== 12'h44E) begin n_err++; $display("FAIL basic_vec got=%h exp=44e", o_vector); end
        step();                       // held without ack
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd5) begin n_err++; $display("FAIL basic_hold irq=%b num=%0d exp irq=1 num=5", o_irq, o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL basic_ack_irq got=%b exp=0", o_irq); end
        n_cmp++; if (o_pending !== 32'h0) begin n_err++; $display("FAIL basic_ack_pend got=%h exp=0", o_pending); end
        step();                       // back to idle
        step();
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL basic_idle_irq got=%b exp=0", o_irq); end
    endtask

    task automatic test_priority();
        i_req = (32'h1 << 3) | (32'h1 << 20);
        step();
        i_req = '0;
        step();                       // first grant
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd3) begin n_err++; $display("FAIL prio_first irq=%b num=%0d exp irq=1 num=3", o_irq, o_num); end
        i_ack = 1'b1;
        step();                       // settle
        i_ack = 1'b0;
        n_cmp++; if (o_irq !== 1'b0 || o_pending !== 32'h0010_0000) begin n_err++; $display("FAIL prio_settle irq=%b pend=%h exp irq=0 pend=00100000", o_irq, o_pending); end
        step();                       // idle
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL prio_gap got=%b exp=0", o_irq); end
        step();                       // second grant, three edges after first
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd20) begin n_err++; $display("FAIL prio_second irq=%b num=%0d exp irq=1 num=20", o_irq, o_num); end
        n_cmp++; if (o_vector !== 12'h000) begin n_err++; $display("FAIL prio_vec20 got=%h exp=000", o_vector); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
    endtask

    task automatic test_mask();
        i_mask = ~(32'h1 << 7);
        i_req  = 32'h1 << 7;
        step();
        i_req = '0;
        step(); step();
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL mask_irq got=%b exp=0", o_irq); end
        n_cmp++; if (o_pending !== 32'h80) begin n_err++; $display("FAIL mask_pend got=%h exp=00000080", o_pending); end
        // An ack with nothing offered must not disturb the masked bit.
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_cmp++; if (o_pending !== 32'h80) begin n_err++; $display("FAIL mask_stray_ack got=%h exp=00000080", o_pending); end
        i_mask = '1;
        step();
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd7) begin n_err++; $display("FAIL mask_unmask irq=%b num=%0d exp irq=1 num=7", o_irq, o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
    endtask

    task automatic test_hold();
        tab_write(5'd9, 12'h123);
        i_req = 32'h1 << 9;
        step();
        i_req = '0;
        step();                       // offering 9
        i_req = 32'h1 << 2;
        i_mask = ~(32'h1 << 9);
        i_tab_we = 1'b1; i_tab_addr = 5'd9; i_tab_data = 12'hABC;
        step();
        i_req = '0; i_tab_we = 1'b0;
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd9) begin n_err++; $display("FAIL hold_num irq=%b num=%0d exp irq=1 num=9", o_irq, o_num); end
        n_cmp++; if (o_vector !== 12'h123) begin n_err++; $display("FAIL hold_vec got=%h exp=123", o_vector); end
        n_cmp++; if (o_pending !== 32'h204) begin n_err++; $display("FAIL hold_pend got=%h exp=00000204", o_pending); end
        step();
        n_cmp++; if (o_num !== 5'd9) begin n_err++; $display("FAIL hold_num2 got=%0d exp=9", o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        step();                       // next grant
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd2) begin n_err++; $display("FAIL hold_next irq=%b num=%0d exp irq=1 num=2", o_irq, o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        i_mask = '1;
        step();
    endtask

    task automatic test_set_wins();
        i_req = 32'h1 << 4;
        step();
        i_req = '0;
        step();                       // offering 4
        i_ack = 1'b1;
        i_req = 32'h1 << 4;
        step();
        i_ack = 1'b0; i_req = '0;
        n_cmp++; if (o_pending !== 32'h10 || o_irq !== 1'b0) begin n_err++; $display("FAIL setwin_ack pend=%h irq=%b exp pend=00000010 irq=0", o_pending, o_irq); end
        step();
        step();
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd4) begin n_err++; $display("FAIL setwin_regrant irq=%b num=%0d exp irq=1 num=4", o_irq, o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        // Software clear against a simultaneous request.
        i_mask = ~(32'h1 << 6);
        i_req = 32'h1 << 6;
        step();
        i_clr = 1'b1; i_clr_num = 5'd6;
        step();
        i_req = '0;
        n_cmp++; if (o_pending !== 32'h40) begin n_err++; $display("FAIL setwin_clr got=%h exp=00000040", o_pending); end
        step();                       // clear alone
        i_clr = 1'b0;
        n_cmp++; if (o_pending !== 32'h0) begin n_err++; $display("FAIL clr_only got=%h exp=0", o_pending); end
        i_mask = '1;
        step();
    endtask

    task automatic test_clr_offered();
        i_req = 32'h1 << 11;
        step();
        i_req = '0;
        step();
        i_clr = 1'b1; i_clr_num = 5'd11;
        step();
        i_clr = 1'b0;
        n_cmp++; if (o_pending !== 32'h0 || o_irq !== 1'b1 || o_num !== 5'd11) begin n_err++; $display("FAIL clroff pend=%h irq=%b num=%0d exp pend=0 irq=1 num=11", o_pending, o_irq, o_num); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL clroff_ack got=%b exp=0", o_irq); end
        step();
    endtask

    task automatic test_tab_collision();
        tab_write(5'd12, 12'h111);
        i_req = 32'h1 << 12;
        step();
        i_req = '0;
        i_tab_we = 1'b1; i_tab_addr = 5'd12; i_tab_data = 12'h222;
        step();                       // latch and write on the same edge
        i_tab_we = 1'b0;
        n_cmp++; if (o_irq !== 1'b1 || o_vector !== 12'h111) begin n_err++; $display("FAIL tabcol irq=%b vec=%h exp irq=1 vec=111", o_irq, o_vector); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
        i_req = 32'h1 << 12;
        step();
        i_req = '0;
        step();
        n_cmp++; if (o_vector !== 12'h222) begin n_err++; $display("FAIL tabcol_new got=%h exp=222", o_vector); end
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
        step();
    endtask

    task automatic test_nmi_and_reset();
        i_mask = '0;
        i_req = 32'h1 << 1;
        step();
        i_req = '0;
        step();
`ifdef INTR_NMI_EN
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd1) begin n_err++; $display("FAIL nmi irq=%b num=%0d exp irq=1 num=1", o_irq, o_num); end
`else
        n_cmp++; if (o_irq !== 1'b0 || o_pending !== 32'h2) begin n_err++; $display("FAIL nmi_masked irq=%b pend=%h exp irq=0 pend=00000002", o_irq, o_pending); end
`endif
        i_mask = '1;
        step();
        n_cmp++; if (o_irq !== 1'b1 || o_num !== 5'd1) begin n_err++; $display("FAIL pre_reset irq=%b num=%0d exp irq=1 num=1", o_irq, o_num); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL async_reset_irq got=%b exp=0", o_irq); end
        n_cmp++; if (o_pending !== 32'h0) begin n_err++; $display("FAIL async_reset_pend got=%h exp=0", o_pending); end
        n_cmp++; if (o_num !== 5'd0) begin n_err++; $display("FAIL async_reset_num got=%0d exp=0", o_num); end
        step();
        reset = 1'b0;
        step();
        n_cmp++; if (o_irq !== 1'b0) begin n_err++; $display("FAIL post_reset_irq got=%b exp=0", o_irq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_hold();
        test_set_wins();
        test_clr_offered();
        test_tab_collision();
        test_nmi_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
